// File: rtl/timer_irq_unit_if.sv
// rtl/timer_irq_unit_if.sv - CPU-side TIFR0 access and interrupt req/ack bundle
interface timer_irq_unit_if #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_WIDTH  = 5
);
   logic                  tifr_we;
   logic [DATA_WIDTH-1:0] tifr_wdata;
   logic                  irq_ack;
   logic [DATA_WIDTH-1:0] tifr0;
   logic                  irq;
   logic [VEC_WIDTH-1:0]  irq_vector;

   modport master (
      output tifr_we, tifr_wdata, irq_ack,
      input  tifr0, irq, irq_vector
   );

   modport slave (
      input  tifr_we, tifr_wdata, irq_ack,
      output tifr0, irq, irq_vector
   );
endinterface

// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - Timer/Counter0 TIFR0 flag keeper and prioritised interrupt requester
module timer_irq_unit #(
   parameter int                   DATA_WIDTH = 8,
   parameter int                   VEC_WIDTH  = 5,
   parameter logic [VEC_WIDTH-1:0] VEC_OCF0A  = 5'd5,
   parameter logic [VEC_WIDTH-1:0] VEC_OCF0B  = 5'd6,
   parameter logic [VEC_WIDTH-1:0] VEC_TOV0   = 5'd4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [DATA_WIDTH-1:0] mem_tcnt0,
   input  logic [DATA_WIDTH-1:0] top,
   input  logic [DATA_WIDTH-1:0] mem_ocr0a,
   input  logic [DATA_WIDTH-1:0] mem_ocr0b,
   input  logic [DATA_WIDTH-1:0] mem_timsk0,
   input  logic                  global_ie,
   timer_irq_unit_if.slave       bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [2:0]           flags, flags_n, flags_sw;
   logic [2:0]           events, sw_clear, hw_clear, pending, enables;
   logic [2:0]           src_q, src_n;
   logic [VEC_WIDTH-1:0] vec_q, vec_n;
   logic                 latch;
   logic [2*(DATA_WIDTH-3)-1:0] unused_bits;

   assign unused_bits = {mem_timsk0[DATA_WIDTH-1:3], bus.tifr_wdata[DATA_WIDTH-1:3]};

   // Bit order everywhere is {OCF0B, OCF0A, TOV0}, matching TIFR0/TIMSK0.
   assign events   = tick ? {mem_tcnt0 == mem_ocr0b, mem_tcnt0 == mem_ocr0a, mem_tcnt0 == top}
                          : 3'b000;
   assign sw_clear = bus.tifr_we ? bus.tifr_wdata[2:0] : 3'b000;
   assign flags_sw = (flags & ~sw_clear) | events;
   assign flags_n  = (flags & ~(sw_clear | hw_clear)) | events;
   assign enables  = mem_timsk0[2:0];
   assign pending  = flags & enables;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         flags <= 3'b000;
         src_q <= 3'b000;
         vec_q <= '0;
      end else begin
         state <= state_n;
         flags <= flags_n;
         if (latch) begin
            src_q <= src_n;
            vec_q <= vec_n;
         end
      end
   end

   always_comb begin
      state_n  = state;
      hw_clear = 3'b000;
      latch    = 1'b0;
      src_n    = src_q;
      vec_n    = vec_q;
      case (state)
         IDLE: begin
            if (global_ie && (pending != 3'b000)) begin
               latch   = 1'b1;
               state_n = REQ;
               if (pending[1]) begin
                  src_n = 3'b010;
                  vec_n = VEC_OCF0A;
               end else if (pending[2]) begin
                  src_n = 3'b100;
                  vec_n = VEC_OCF0B;
               end else begin
                  src_n = 3'b001;
                  vec_n = VEC_TOV0;
               end
            end
         end
         REQ: begin
            // A software clear takes effect the same cycle it is written, so irq drops right after it.
            if (bus.irq_ack) begin
               hw_clear = src_q;
               state_n  = HOLD;
            end else if (((flags_sw & src_q) == 3'b000) || ((enables & src_q) == 3'b000) || !global_ie) begin
               state_n = IDLE;
            end
         end
         HOLD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.tifr0      = {{(DATA_WIDTH-3){1'b0}}, flags};
   assign bus.irq        = (state == REQ);
   assign bus.irq_vector = (state == REQ) ? vec_q : '0;

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Interrupt stage directly downstream of the 8-bit Timer/Counter0 unit.
- Detects overflow and compare-match A/B events from the counter's per-tick state and maintains the TIFR0 flags (OCF0B, OCF0A, TOV0) under the TIMSK0 enables.
- Presents one prioritised interrupt request with its vector to the CPU interrupt controller, using a req/ack handshake.
- Gives the CPU write-1-to-clear access to TIFR0.

Parameters:
- DATA_WIDTH, 8, width of counter, compare and register values
- VEC_WIDTH, 5, width of the vector output
- VEC_OCF0A, 5'd5, vector index for compare match A
- VEC_OCF0B, 5'd6, vector index for compare match B
- VEC_TOV0, 5'd4, vector index for overflow

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- tick  in  1  one-cycle pulse in the clk cycle in which the timer advances (timer clock edge)
- mem_tcnt0  in  DATA_WIDTH  counter value before the advance in the tick cycle
- top  in  DATA_WIDTH  current TOP value from the timer unit
- mem_ocr0a  in  DATA_WIDTH  compare value, channel A
- mem_ocr0b  in  DATA_WIDTH  compare value, channel B
- mem_timsk0  in  DATA_WIDTH  bit2 OCIE0B, bit1 OCIE0A, bit0 TOIE0; other bits ignored
- global_ie  in  1  SREG I bit
- tifr_we  in  1  CPU write strobe to TIFR0
- tifr_wdata  in  DATA_WIDTH  write data; a 1 in bits [2:0] clears the corresponding flag
- irq_ack  in  1  CPU accepts the pending request (one-cycle pulse)
- tifr0  out  DATA_WIDTH  {5'b0, OCF0B, OCF0A, TOV0}
- irq  out  1  interrupt request
- irq_vector  out  VEC_WIDTH  vector of the pending request; valid while irq=1

Behaviour:
- Reset (reset==0 at a clk edge):
  - tifr0 = 0, irq = 0, irq_vector = 0, FSM = IDLE.
  - Reset dominates every other input, including mid-handshake.
- Event detection (only in cycles with tick=1):
  - TOV0 event: mem_tcnt0 == top.
  - OCF0A event: mem_tcnt0 == mem_ocr0a.
  - OCF0B event: mem_tcnt0 == mem_ocr0b.
  - Several events may occur in the same tick; all are flagged.
  - tick=0 means no events (timer stopped, CS0=0).
- Flag update, per bit, each cycle:
  - next = (flag & ~clear) | set.
  - clear = (tifr_we & tifr_wdata[i]) | hw_clear[i].
  - A set always wins over a clear in the same cycle.
  - Writing 0 to a bit has no effect. Bits [7:3] read 0.
  - Latency: a flag is visible on tifr0 one clk after its event or its clear.
- Pending vector, each cycle:
  - pending = tifr0[2:0] & mem_timsk0[2:0].
  - Priority is OCF0A > OCF0B > TOV0.
- FSM states:
  - IDLE: irq=0. If global_ie && pending != 0, latch the highest-priority source and its vector, go to REQ. irq rises one clk after the qualifying flag is visible.
  - REQ: irq=1; irq_vector and the latched source are held stable even if a higher-priority flag sets meanwhile.
    - On irq_ack: hw_clear the latched flag in that cycle, go to HOLD.
    - On withdraw without ack (the latched flag cleared by software, its enable bit dropped, or global_ie=0): go to IDLE with irq=0 next cycle.
    - irq_ack and withdraw in the same cycle: ack wins.
  - HOLD: irq=0 for exactly one cycle, then IDLE. This gives the CPU I-bit clear time to propagate.
- irq_ack outside REQ is ignored.
- irq_vector reads 0 whenever irq=0.
- Equality comparisons are unsigned and full width; no wrap handling beyond the counter's own.

Test Plan:
- Reset: drive reset=0 for 2 cycles during REQ -> irq=0, tifr0=0x00, FSM in IDLE. Release reset with no stimulus -> outputs stay 0.
- Overflow: top=0xFF, mem_timsk0=0x01, global_ie=1, tick with mem_tcnt0=0xFF -> tifr0=0x01 next clk, then irq=1 with irq_vector=4. irq_ack -> TOV0 cleared, irq=0 for one HOLD cycle, no re-request.
- Priority: mem_ocr0a=mem_ocr0b=0x40, mem_timsk0=0x07, tick at mem_tcnt0=0x40 -> tifr0=0x06, irq_vector=5. After ack -> tifr0=0x04, then a new request with irq_vector=6.
- Set vs clear: tifr_we=1, tifr_wdata=0x02 in the same cycle as an OCF0A event -> OCF0A stays 1. Write 0x02 in a later cycle -> tifr0 bit1 = 0.
- Withdraw: in REQ for TOV0, write tifr_wdata=0x01 -> irq drops next cycle with no ack, FSM in IDLE.
- Masking: mem_timsk0=0x00 or global_ie=0 with events -> flags set in tifr0, irq stays 0. Set global_ie=1 with TOIE0 enabled -> irq asserts one clk later.
